mont_const_loader: RTL and testbench

Receives the Montgomery constants streamed out of the secondary-input stage and holds them for the modular-multiplier datapath. It takes one 32-bit word each of R mod n and R² mod n (t) per valid cycle, most-significant word first, together with n0′. It stores them in two word-addressable 32×32 register files and flags when a complete, consistent set is ready. It sits between the constant generator and the Montgomery multiplier's operand fetch.

---
 rtl/mont_pkg.sv | 7 +
 rtl/mont_word_rf.sv | 32 +++
 rtl/mont_const_loader.sv | 88 ++++++++
 tb/tb_mont_const_loader.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// mont_pkg: shared Montgomery constant-store parameters and loader states
package mont_pkg;
   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 32;
   localparam int ADDR_W    = $clog2(NUM_WORDS);
   typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;
endpackage

// File: rtl/mont_word_rf.sv
// mont_word_rf: word register file, one write port, one registered read port
module mont_word_rf #(
   parameter int WORD_W    = mont_pkg::WORD_W,
   parameter int NUM_WORDS = mont_pkg::NUM_WORDS,
   parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem_q [NUM_WORDS];
   logic [WORD_W-1:0] mem_d [NUM_WORDS];
   logic [WORD_W-1:0] rdata_q;
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end
   // read samples mem_q, so a same-edge write returns the old word
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         rdata_q <= '0;
      end else begin
         mem_q   <= mem_d;
         rdata_q <= mem_q[raddr];
      end
   assign rdata = rdata_q;
endmodule

// File: rtl/mont_const_loader.sv
// mont_const_loader: captures streamed R mod n, R^2 mod n and n0' for the Montgomery multiplier
module mont_const_loader #(
   parameter int WORD_W    = mont_pkg::WORD_W,
   parameter int NUM_WORDS = mont_pkg::NUM_WORDS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start_transfer,
   input  logic                         word_valid,
   input  logic [WORD_W-1:0]            r_word,
   input  logic [WORD_W-1:0]            t_word,
   input  logic [WORD_W-1:0]            n0p_in,
   input  logic                         consts_release,
   input  logic [$clog2(NUM_WORDS)-1:0] rd_addr,
   output logic [WORD_W-1:0]            r_rd_data,
   output logic [WORD_W-1:0]            t_rd_data,
   output logic [WORD_W-1:0]            n0p,
   output logic                         consts_valid,
   output logic                         busy,
   output logic                         overrun
);
   import mont_pkg::*;
   localparam int AW    = $clog2(NUM_WORDS);
   localparam int CNT_W = AW + 1;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic [WORD_W-1:0] n0p_q, n0p_d;
   logic              cv_q, cv_d, ovr_q, ovr_d, we;
   logic [AW-1:0]     waddr;
   // stream arrives MS word first, so the first word lands at the top address
   assign waddr = AW'(NUM_WORDS - 1) - wcnt_q[AW-1:0];
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      n0p_d   = n0p_q;
      cv_d    = cv_q;
      ovr_d   = ovr_q;
      we      = 1'b0;
      if (start_transfer) begin
         state_d = LOAD;
         wcnt_d  = '0;
         cv_d    = 1'b0;
         ovr_d   = 1'b0;
      end else if (state_q == LOAD) begin
         if (word_valid) begin
            we     = 1'b1;
            wcnt_d = wcnt_q + CNT_W'(1);
            if (wcnt_q == CNT_W'(NUM_WORDS - 1)) begin
               state_d = READY;
               cv_d    = 1'b1;
               n0p_d   = n0p_in;
            end
         end
      end else begin
         ovr_d = ovr_q | word_valid;
         if (state_q == READY && consts_release) begin
            state_d = IDLE;
            cv_d    = 1'b0;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         n0p_q   <= '0;
         cv_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         n0p_q   <= n0p_d;
         cv_q    <= cv_d;
         ovr_q   <= ovr_d;
      end
   mont_word_rf #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) u_r_rf (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(r_word),
      .raddr(rd_addr), .rdata(r_rd_data)
   );
   mont_word_rf #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) u_t_rf (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(t_word),
      .raddr(rd_addr), .rdata(t_rd_data)
   );
   assign n0p          = n0p_q;
   assign consts_valid = cv_q;
   assign busy         = (state_q == LOAD);
   assign overrun      = ovr_q;
endmodule

// File: tb/tb_mont_const_loader.sv
// tb_mont_const_loader: directed checks of the Montgomery constant loader
module tb_mont_const_loader;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start_transfer = 1'b0, word_valid = 1'b0, consts_release = 1'b0;
   logic [31:0] r_word = '0, t_word = '0, n0p_in = '0;
   logic [4:0]  rd_addr = '0;
   logic [31:0] r_rd_data, t_rd_data, n0p;
   logic        consts_valid, busy, overrun;
   int          checks = 0, failures = 0;

   mont_const_loader dut (
      .clk(clk), .rst_n(rst_n), .start_transfer(start_transfer), .word_valid(word_valid),
      .r_word(r_word), .t_word(t_word), .n0p_in(n0p_in), .consts_release(consts_release),
      .rd_addr(rd_addr), .r_rd_data(r_rd_data), .t_rd_data(t_rd_data), .n0p(n0p),
      .consts_valid(consts_valid), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start pulse with a junk word alongside, which must be ignored
   task automatic start();
      start_transfer = 1'b1;
      word_valid     = 1'b1;
      r_word         = 32'hFFFF_FFFF;
      t_word         = 32'hFFFF_FFFF;
      tick();
      start_transfer = 1'b0;
      word_valid     = 1'b0;
   endtask

   task automatic stream(input logic [31:0] rb, input logic [31:0] tb, input int first,
                         input int n, input bit gaps);
      for (int i = first; i < first + n; i++) begin
         word_valid = 1'b1;
         r_word     = rb + 32'(i);
         t_word     = tb + 32'(i);
         tick();
         if (gaps) begin
            word_valid = 1'b0;
            r_word     = 32'hDEAD_0000;
            tick();
         end
      end
      word_valid = 1'b0;
   endtask

   // address a holds stream word 31-a; zero selects an all-zero expectation
   task automatic read_sweep(input string tag, input logic [31:0] rb, input logic [31:0] tb,
                             input bit zero);
      for (int a = 0; a < 32; a++) begin
         rd_addr = 5'(a);
         tick();
         chk($sformatf("%s_r%0d", tag, a), r_rd_data, zero ? 32'h0 : rb + 32'(31 - a));
         chk($sformatf("%s_t%0d", tag, a), t_rd_data, zero ? 32'h0 : tb + 32'(31 - a));
      end
   endtask

   initial begin
      #1;
      chk("rst_cv", 32'(consts_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_n0p", n0p, 0);
      tick();
      rst_n = 1'b1;
      tick();
      read_sweep("idle", 0, 0, 1'b1);
      chk("idle_cv", 32'(consts_valid), 0);

      n0p_in = 32'hDEAD_BEEF;
      start();
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_cv0", 32'(consts_valid), 0);
      stream(32'h1000_0000, 32'h2000_0000, 0, 31, 1'b0);
      chk("b2b_cv_pre", 32'(consts_valid), 0);
      chk("b2b_busy_pre", 32'(busy), 1);
      stream(32'h1000_0000, 32'h2000_0000, 31, 1, 1'b0);
      chk("b2b_cv", 32'(consts_valid), 1);
      chk("b2b_busy_done", 32'(busy), 0);
      chk("b2b_n0p", n0p, 32'hDEAD_BEEF);
      chk("b2b_ovr", 32'(overrun), 0);
      read_sweep("b2b", 32'h1000_0000, 32'h2000_0000, 1'b0);

      consts_release = 1'b1;
      tick();
      consts_release = 1'b0;
      chk("rel_cv", 32'(consts_valid), 0);
      chk("rel_busy", 32'(busy), 0);
      consts_release = 1'b1;
      tick();
      consts_release = 1'b0;
      chk("rel_idle_cv", 32'(consts_valid), 0);
      chk("rel_idle_busy", 32'(busy), 0);

      start();
      stream(32'h1000_0000, 32'h2000_0000, 0, 31, 1'b1);
      chk("gap_cv_pre", 32'(consts_valid), 0);
      stream(32'h1000_0000, 32'h2000_0000, 31, 1, 1'b1);
      chk("gap_cv", 32'(consts_valid), 1);
      read_sweep("gap", 32'h1000_0000, 32'h2000_0000, 1'b0);

      // start from READY with a simultaneous release: start wins
      consts_release = 1'b1;
      start();
      consts_release = 1'b0;
      chk("rs_cv", 32'(consts_valid), 0);
      chk("rs_busy", 32'(busy), 1);
      stream(32'h5555_0000, 32'h6666_0000, 0, 10, 1'b0);
      start();
      stream(32'hA5A5_0000, 32'h5A5A_0000, 0, 31, 1'b0);
      chk("rs_cv_pre", 32'(consts_valid), 0);
      stream(32'hA5A5_0000, 32'h5A5A_0000, 31, 1, 1'b0);
      chk("rs_cv", 32'(consts_valid), 1);
      read_sweep("rs", 32'hA5A5_0000, 32'h5A5A_0000, 1'b0);

      word_valid = 1'b1;
      r_word     = 32'hFFFF_FFFF;
      t_word     = 32'hFFFF_FFFF;
      tick();
      word_valid = 1'b0;
      chk("ovr_set", 32'(overrun), 1);
      chk("ovr_cv", 32'(consts_valid), 1);
      read_sweep("ovr", 32'hA5A5_0000, 32'h5A5A_0000, 1'b0);
      consts_release = 1'b1;
      tick();
      consts_release = 1'b0;
      chk("ovr_rel_cv", 32'(consts_valid), 0);
      chk("ovr_sticky", 32'(overrun), 1);
      start();
      chk("ovr_clr", 32'(overrun), 0);
      chk("ovr_busy", 32'(busy), 1);

      stream(32'h1000_0000, 32'h2000_0000, 0, 20, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_cv", 32'(consts_valid), 0);
      chk("arst_n0p", n0p, 0);
      chk("arst_r", r_rd_data, 0);
      tick();
      rst_n = 1'b1;
      read_sweep("arst", 0, 0, 1'b1);
      repeat (40) tick();
      chk("arst_cv_idle", 32'(consts_valid), 0);
      chk("arst_busy_idle", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
